// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared state encodings and port indices for the memory port arbiter
package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Select values for the external addr/wdata muxes
   localparam logic P_IF = 1'b0;
   localparam logic P_DM = 1'b1;

endpackage

// File: rtl/arb_timeout_cnt.sv
// rtl/arb_timeout_cnt.sv - BUSY cycle counter flagging expiry at TIMEOUT-1
module arb_timeout_cnt #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   generate
      if (TIMEOUT == 0) begin : g_off
         logic unused_inputs;
         assign unused_inputs = ^{clk, reset, clr, en};
         assign expired = 1'b0;
      end else begin : g_cnt
         localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
         logic [CW-1:0] cnt_q;
         logic [CW-1:0] cnt_d;

         always_comb begin
            cnt_d = cnt_q;
            if (clr) begin
               cnt_d = '0;
            end else if (en) begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         always_ff @(posedge clk) begin
            if (reset) begin
               cnt_q <= '0;
            end else begin
               cnt_q <= cnt_d;
            end
         end

         // Expiry leaves BUSY, so the counter never runs past LAST
         assign expired = en && (cnt_q == LAST);
      end
   endgenerate

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-port arbiter sequencing the shared data-memory handshake
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned TIMEOUT    = 16,
   parameter bit          FIXED_PRIO = 1'b0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req0,
   input  logic        we0,
   input  logic        req1,
   input  logic        we1,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        mem_sel,
   output logic        mem_req,
   output logic        mem_we,
   output logic        gnt0,
   output logic        gnt1,
   output logic        done0,
   output logic        done1,
   output logic [31:0] rdata,
   output logic        err
);

   state_e      state_q, state_d;
   logic        sel_q, sel_d;
   logic        last_q, last_d;
   logic        err_q, err_d;
   logic [31:0] rdata_q, rdata_d;
   logic        busy;
   logic        expired;

   assign busy = (state_q == ST_BUSY);

   arb_timeout_cnt #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout_cnt (
      .clk     (clk),
      .reset   (reset),
      .clr     (!busy),
      .en      (busy),
      .expired (expired)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         sel_q   <= P_IF;
         last_q  <= P_DM;
         err_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         last_q  <= last_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
      end
   end

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      last_d  = last_q;
      err_d   = err_q;
      rdata_d = rdata_q;
      unique case (state_q)
         ST_IDLE: begin
            if (req0 || req1) begin
               state_d = ST_BUSY;
               if (req0 && req1) begin
                  sel_d = FIXED_PRIO ? P_DM : ~last_q;
               end else begin
                  sel_d = req1 ? P_DM : P_IF;
               end
            end
         end
         ST_BUSY: begin
            // An ack on the expiry cycle still counts as a normal completion
            if (mem_ack) begin
               state_d = ST_DONE;
               rdata_d = mem_rdata;
               last_d  = sel_q;
               err_d   = 1'b0;
            end else if (expired) begin
               state_d = ST_DONE;
               rdata_d = '0;
               last_d  = sel_q;
               err_d   = 1'b1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_comb begin
      mem_sel = sel_q;
      mem_req = busy;
      mem_we  = busy && (sel_q ? we1 : we0);
      gnt0    = busy && (sel_q == P_IF);
      gnt1    = busy && (sel_q == P_DM);
      done0   = (state_q == ST_DONE) && (sel_q == P_IF);
      done1   = (state_q == ST_DONE) && (sel_q == P_DM);
      err     = (state_q == ST_DONE) && err_q;
      rdata   = rdata_q;
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter (round-robin and fixed-priority)
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = '0;

   logic        rr_sel, rr_req, rr_we, rr_g0, rr_g1, rr_d0, rr_d1, rr_err;
   logic [31:0] rr_rdata;
   logic        fp_sel, fp_req, fp_we, fp_g0, fp_g1, fp_d0, fp_d1, fp_err;
   logic [31:0] fp_rdata;
   logic [39:0] rr_vec, fp_vec;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.TIMEOUT(16), .FIXED_PRIO(1'b0)) u_rr (
      .clk(clk), .reset(reset), .req0(req0), .we0(we0), .req1(req1), .we1(we1),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_sel(rr_sel), .mem_req(rr_req),
      .mem_we(rr_we), .gnt0(rr_g0), .gnt1(rr_g1), .done0(rr_d0), .done1(rr_d1),
      .rdata(rr_rdata), .err(rr_err));

   mem_port_arbiter #(.TIMEOUT(16), .FIXED_PRIO(1'b1)) u_fp (
      .clk(clk), .reset(reset), .req0(req0), .we0(we0), .req1(req1), .we1(we1),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_sel(fp_sel), .mem_req(fp_req),
      .mem_we(fp_we), .gnt0(fp_g0), .gnt1(fp_g1), .done0(fp_d0), .done1(fp_d1),
      .rdata(fp_rdata), .err(fp_err));

   assign rr_vec = {rr_sel, rr_req, rr_we, rr_g0, rr_g1, rr_d0, rr_d1, rr_err, rr_rdata};
   assign fp_vec = {fp_sel, fp_req, fp_we, fp_g0, fp_g1, fp_d0, fp_d1, fp_err, fp_rdata};

   // Reference model, one per instance (index 1 = fixed priority): owner, age of the
   // current transaction and the last completed owner.
   bit          m_busy[2], m_done[2], m_sel[2], m_last[2], m_err[2];
   int          m_age[2];
   logic [31:0] m_rdata[2];

   task automatic model_step();
      for (int k = 0; k < 2; k++) begin
         if (reset) begin
            m_busy[k] = 0; m_done[k] = 0; m_sel[k] = 0; m_last[k] = 1;
            m_err[k] = 0; m_age[k] = 0; m_rdata[k] = '0;
         end else if (m_done[k]) begin
            m_done[k] = 0;
         end else if (m_busy[k]) begin
            m_age[k]++;
            if (mem_ack || m_age[k] == 16) begin
               m_err[k]   = !mem_ack;
               m_rdata[k] = mem_ack ? mem_rdata : 32'h0;
               m_last[k]  = m_sel[k];
               m_busy[k]  = 0;
               m_done[k]  = 1;
            end
         end else if (req0 || req1) begin
            if (req0 && req1) m_sel[k] = (k == 1) ? 1'b1 : !m_last[k];
            else              m_sel[k] = req1;
            m_busy[k] = 1;
            m_age[k]  = 0;
         end
      end
   endtask

   function automatic logic [39:0] exp_vec(int k);
      logic b, s, d;
      b = m_busy[k]; s = m_sel[k]; d = m_done[k];
      return {s, b, b & (s ? we1 : we0), b & ~s, b & s, d & ~s, d & s, d & m_err[k], m_rdata[k]};
   endfunction

   task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      check("model_rr", rr_vec, exp_vec(0));
      check("model_fp", fp_vec, exp_vec(1));
   endtask

   task automatic set_in(input logic rst, input logic r0, input logic w0, input logic r1,
                         input logic w1, input logic ack, input logic [31:0] rd);
      reset = rst; req0 = r0; we0 = w0; req1 = r1; we1 = w1; mem_ack = ack; mem_rdata = rd;
   endtask

   typedef struct {
      logic        rst, r0, w0, r1, w1, ack;
      logic [31:0] rd;
      logic [39:0] exp;
   } vec_t;

   function automatic vec_t mkv(input logic rst, input logic r0, input logic w0, input logic r1,
                                input logic w1, input logic ack, input logic [31:0] rd,
                                input logic [7:0] flags, input logic [31:0] erd);
      vec_t v;
      v.rst = rst; v.r0 = r0; v.w0 = w0; v.r1 = r1; v.w1 = w1; v.ack = ack; v.rd = rd;
      v.exp = {flags, erd};
      return v;
   endfunction

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vec_t tbl[16];
      logic exp_rr[3];
      int   n_req;

      // flags = {sel, req, we, gnt0, gnt1, done0, done1, err}
      tbl[0]  = mkv(1, 0,0, 0,0, 0, 32'h0,        8'b0000_0000, 32'h0);
      tbl[1]  = mkv(1, 0,0, 0,0, 0, 32'h0,        8'b0000_0000, 32'h0);
      tbl[2]  = mkv(1, 0,0, 0,0, 0, 32'h0,        8'b0000_0000, 32'h0);
      tbl[3]  = mkv(0, 0,0, 0,0, 0, 32'h0,        8'b0000_0000, 32'h0);
      tbl[4]  = mkv(0, 0,0, 0,0, 1, 32'h12345678, 8'b0000_0000, 32'h0);
      tbl[5]  = mkv(0, 1,0, 0,0, 0, 32'h0,        8'b0101_0000, 32'h0);
      tbl[6]  = mkv(0, 1,0, 0,0, 0, 32'h0,        8'b0101_0000, 32'h0);
      tbl[7]  = mkv(0, 1,0, 0,0, 1, 32'hDEADBEEF, 8'b0000_0100, 32'hDEADBEEF);
      tbl[8]  = mkv(0, 0,0, 0,0, 0, 32'h0,        8'b0000_0000, 32'hDEADBEEF);
      tbl[9]  = mkv(0, 1,1, 0,0, 0, 32'h0,        8'b0111_0000, 32'hDEADBEEF);
      tbl[10] = mkv(0, 1,1, 0,0, 1, 32'h00001111, 8'b0000_0100, 32'h00001111);
      tbl[11] = mkv(0, 0,0, 1,0, 0, 32'h0,        8'b0000_0000, 32'h00001111);
      tbl[12] = mkv(0, 0,0, 1,0, 0, 32'h0,        8'b1100_1000, 32'h00001111);
      tbl[13] = mkv(0, 0,0, 1,0, 1, 32'hA5A5A5A5, 8'b1000_0010, 32'hA5A5A5A5);
      tbl[14] = mkv(0, 0,0, 0,0, 0, 32'h0,        8'b1000_0000, 32'hA5A5A5A5);
      tbl[15] = mkv(0, 0,0, 0,0, 1, 32'hFFFFFFFF, 8'b1000_0000, 32'hA5A5A5A5);

      for (int i = 0; i < 16; i++) begin
         set_in(tbl[i].rst, tbl[i].r0, tbl[i].w0, tbl[i].r1, tbl[i].w1, tbl[i].ack, tbl[i].rd);
         tick();
         check($sformatf("vec%0d_rr", i), rr_vec, tbl[i].exp);
         check($sformatf("vec%0d_fp", i), fp_vec, tbl[i].exp);
      end

      // Tie held for three transactions: round-robin 0,1,0; fixed priority always 1
      set_in(1, 0,0, 0,0, 0, 32'h0); tick();
      set_in(0, 1,0, 1,0, 0, 32'h0);
      exp_rr[0] = 1'b0; exp_rr[1] = 1'b1; exp_rr[2] = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         check($sformatf("tie%0d_rr_sel", k), 40'(rr_sel), 40'(exp_rr[k]));
         check($sformatf("tie%0d_fp_sel", k), 40'(fp_sel), 40'(1));
         check($sformatf("tie%0d_req", k), 40'({rr_req, fp_req}), 40'(2'b11));
         tick();
         check($sformatf("tie%0d_rr_sel_stable", k), 40'(rr_sel), 40'(exp_rr[k]));
         mem_ack = 1'b1; mem_rdata = 32'h100 + 32'(k);
         tick();
         check($sformatf("tie%0d_rr_done", k), 40'({rr_d0, rr_d1}), 40'(exp_rr[k] ? 2'b01 : 2'b10));
         check($sformatf("tie%0d_fp_done", k), 40'({fp_d0, fp_d1}), 40'(2'b01));
         mem_ack = 1'b0;
         tick();
      end

      // Timeout: mem_req for exactly 16 cycles, then done1 with err and rdata cleared
      set_in(1, 0,0, 0,0, 0, 32'h0); tick();
      set_in(0, 0,0, 1,1, 0, 32'h0); tick();
      set_in(0, 0,0, 1,1, 1, 32'hFFFF0000); tick();
      set_in(0, 0,0, 0,0, 0, 32'h0); tick();
      check("to_prime_rdata", 40'(rr_rdata), 40'(32'hFFFF0000));
      set_in(0, 0,0, 1,1, 0, 32'h13572468);
      n_req = 0;
      for (int c = 0; c < 40; c++) begin
         tick();
         if (rr_req) n_req++;
         if (rr_d1) break;
      end
      check("to_req_cycles", 40'(n_req), 40'(16));
      check("to_done_err_rr", 40'({rr_d1, rr_err, rr_rdata}), {6'b0, 2'b11, 32'h0});
      check("to_done_err_fp", 40'({fp_d1, fp_err, fp_rdata}), {6'b0, 2'b11, 32'h0});
      set_in(0, 0,0, 0,0, 0, 32'h0); tick();
      check("to_idle_after", 40'({rr_req, rr_d1, rr_err}), 40'(0));

      // Reset during the 2nd BUSY cycle restores last=1 so the next tie goes to port0
      set_in(1, 0,0, 0,0, 0, 32'h0); tick();
      set_in(0, 1,0, 1,0, 0, 32'h0); tick();
      set_in(0, 1,0, 1,0, 1, 32'h0); tick();
      set_in(0, 0,0, 0,0, 0, 32'h0); tick();
      set_in(0, 0,0, 1,0, 0, 32'h0); tick();
      tick();
      reset = 1'b1; tick();
      set_in(0, 0,0, 0,0, 1, 32'hCAFEF00D); tick();
      check("rst_busy_no_done", 40'({rr_req, rr_d0, rr_d1, fp_d0, fp_d1}), 40'(0));
      check("rst_busy_rdata", 40'(rr_rdata), 40'(0));
      set_in(0, 1,0, 1,0, 0, 32'h0); tick();
      check("rst_busy_next_tie", 40'({rr_sel, rr_req}), 40'(2'b01));
      mem_ack = 1'b1; tick();
      set_in(0, 0,0, 0,0, 0, 32'h0); tick();

      // Ack on the expiry cycle wins: completes without err
      set_in(1, 0,0, 0,0, 0, 32'h0); tick();
      set_in(0, 1,0, 0,0, 0, 32'h0); tick();
      repeat (15) tick();
      check("ack_at_limit_still_busy", 40'(rr_req), 40'(1));
      set_in(0, 1,0, 0,0, 1, 32'h12345678); tick();
      check("ack_at_limit_done", 40'({rr_d0, rr_err, rr_rdata}), {6'b0, 2'b10, 32'h12345678});
      set_in(0, 0,0, 0,0, 0, 32'h0); tick();

      // Randomized traffic against the model, including ignored acks and rare resets
      set_in(1, 0,0, 0,0, 0, 32'h0); tick();
      reset = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         if (!req0) begin
            if ($urandom_range(2) == 0) begin req0 = 1'b1; we0 = 1'($urandom_range(1)); end
         end else if ($urandom_range(7) == 0) begin
            req0 = 1'b0;
         end
         if (!req1) begin
            if ($urandom_range(2) == 0) begin req1 = 1'b1; we1 = 1'($urandom_range(1)); end
         end else if ($urandom_range(7) == 0) begin
            req1 = 1'b0;
         end
         if ((c / 500) % 3 == 2) mem_ack = ($urandom_range(24) == 0);
         else                    mem_ack = ($urandom_range(2) == 0);
         mem_rdata = $urandom;
         reset = ($urandom_range(299) == 0);
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
